// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch (IF) stage.
//   fetch_state_t     : fetch FSM states
//                         S_REQ  - request the word at pc
//                         S_WAIT - one request outstanding, waiting for data
//                         S_HOLD - decode stalled, fetched word parked in buffer
//                         S_DROP - one stale (wrong-path) response still to come
//   DEFAULT_NOP_INSTR : bubble encoding (all-zero decodes as NOP)
//   PC_INCR           : byte distance between consecutive instructions
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
    localparam int unsigned PC_INCR           = 4;

endpackage : fetch_pkg

// File: rtl/if_hold_buffer.sv
// -----------------------------------------------------------------------------
// if_hold_buffer
// One-entry parking register for a fetched {nextPC, IR} pair that arrived
// while decode was stalled.
// Ports:
//   clock, reset   : clock, asynchronous active-high reset (empties the entry)
//   write_i        : capture wr_next_pc_i / wr_ir_i and mark the entry valid
//   read_i         : entry is being consumed this cycle; clear valid
//   flush_i        : discard the entry (redirect); wins over write and read
//   wr_next_pc_i   : PC+4 of the word being parked
//   wr_ir_i        : instruction word being parked
//   valid_o        : entry holds a word
//   rd_next_pc_o   : parked PC+4
//   rd_ir_o        : parked instruction word
// -----------------------------------------------------------------------------
module if_hold_buffer #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    write_i,
    input  logic                    read_i,
    input  logic                    flush_i,
    input  logic [ADDRESS_SIZE-1:0] wr_next_pc_i,
    input  logic [DATA_SIZE-1:0]    wr_ir_i,
    output logic                    valid_o,
    output logic [ADDRESS_SIZE-1:0] rd_next_pc_o,
    output logic [DATA_SIZE-1:0]    rd_ir_o
);

    logic                    valid_q;
    logic                    valid_d;
    logic [ADDRESS_SIZE-1:0] next_pc_q;
    logic [DATA_SIZE-1:0]    ir_q;

    always_comb begin
        // NOTE: default assignment first so every path drives valid_d; no latch.
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (write_i) begin
            valid_d = 1'b1;
        end else if (read_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: the payload has no reset; valid_q alone says whether it is meaningful.
    always_ff @(posedge clock) begin
        if (write_i && !flush_i) begin
            next_pc_q <= wr_next_pc_i;
            ir_q      <= wr_ir_i;
        end
    end

    assign valid_o      = valid_q;
    assign rd_next_pc_o = next_pc_q;
    assign rd_ir_o      = ir_q;

endmodule : if_hold_buffer

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// IF stage of the 5-stage MIPS pipeline. Owns the PC, fetches instructions
// over a valid/ready request + single-cycle valid response interface with at
// most one request outstanding, and drives the IF/ID register read by decode.
// Ports:
//   clock              : single rising-edge clock
//   reset              : asynchronous, active-high
//   id_stall_c         : decode is stalled; IF/ID must hold its contents
//   EX_MEM_changePC_c  : redirect (taken branch / jump) from EX/MEM
//   EX_MEM_targetPC    : redirect target (low two bits ignored)
//   imem_req_valid     : fetch request valid
//   imem_req_addr      : fetch address, word aligned
//   imem_req_ready     : memory accepts the request this cycle
//   imem_resp_valid    : instruction data valid (one-cycle pulse)
//   imem_resp_data     : instruction word
//   IF_ID_nextPC       : PC+4 of the instruction in IF_ID_IR (0 for a bubble)
//   IF_ID_IR           : instruction presented to decode
//   if_stall_c         : IF/ID is being loaded with a bubble this cycle
// Throughput: when a response is taken straight into IF/ID, the next request
// (to pc+4) is raised in the same cycle, so a zero-wait memory sustains one
// instruction per clock.
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDRESS_SIZE = 32,
    parameter int                    DATA_SIZE    = 32,
    parameter logic [ADDRESS_SIZE-1:0] RESET_PC   = '0,
    parameter logic [DATA_SIZE-1:0]  NOP_INSTR    = DEFAULT_NOP_INSTR
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    id_stall_c,
    input  logic                    EX_MEM_changePC_c,
    input  logic [ADDRESS_SIZE-1:0] EX_MEM_targetPC,
    output logic                    imem_req_valid,
    output logic [ADDRESS_SIZE-1:0] imem_req_addr,
    input  logic                    imem_req_ready,
    input  logic                    imem_resp_valid,
    input  logic [DATA_SIZE-1:0]    imem_resp_data,
    output logic [ADDRESS_SIZE-1:0] IF_ID_nextPC,
    output logic [DATA_SIZE-1:0]    IF_ID_IR,
    output logic                    if_stall_c
);

    localparam logic [ADDRESS_SIZE-1:0] PC_STEP    = ADDRESS_SIZE'(PC_INCR);
    localparam logic [ADDRESS_SIZE-1:0] ALIGN_MASK = ~ADDRESS_SIZE'(PC_INCR - 1);
    localparam logic [ADDRESS_SIZE-1:0] RESET_PC_W = RESET_PC & ALIGN_MASK;

    fetch_state_t            state_q;
    logic [ADDRESS_SIZE-1:0] pc_q;
    logic [ADDRESS_SIZE-1:0] if_id_next_pc_q;
    logic [DATA_SIZE-1:0]    if_id_ir_q;

    logic [ADDRESS_SIZE-1:0] pc_plus4;
    logic                    resp_in_wait;
    logic                    take_direct;
    logic                    buf_write;
    logic                    buf_read;
    logic                    deliver;
    logic                    early_req;
    logic                    req_fire;

    logic                    buf_valid;
    logic [ADDRESS_SIZE-1:0] buf_next_pc;
    logic [DATA_SIZE-1:0]    buf_ir;

    // -------------------------------------------------------------------------
    // Cycle decode. A redirect suppresses every normal action: a response that
    // coincides with it is wrong-path, and so is any word waiting in the buffer.
    // -------------------------------------------------------------------------
    always_comb begin
        pc_plus4     = pc_q + PC_STEP;
        resp_in_wait = (state_q == S_WAIT) && imem_resp_valid;

        // Response goes straight into IF/ID when decode can take it,
        // otherwise it is parked in the hold buffer.
        take_direct  = resp_in_wait && !EX_MEM_changePC_c && !id_stall_c;
        buf_write    = resp_in_wait && !EX_MEM_changePC_c &&  id_stall_c;
        buf_read     = (state_q == S_HOLD) && buf_valid &&
                       !EX_MEM_changePC_c && !id_stall_c;
        deliver      = take_direct || buf_read;

        // Back-to-back fetch: ask for pc+4 while accepting the word at pc.
        early_req      = take_direct;
        imem_req_valid = !reset && ((state_q == S_REQ) || early_req);
        imem_req_addr  = early_req ? pc_plus4 : pc_q;
        req_fire       = imem_req_valid && imem_req_ready;

        // Bubble whenever IF/ID is refilled without a real instruction.
        if_stall_c   = reset || EX_MEM_changePC_c || (!id_stall_c && !deliver);
    end

    if_hold_buffer #(
        .ADDRESS_SIZE (ADDRESS_SIZE),
        .DATA_SIZE    (DATA_SIZE)
    ) u_hold_buffer (
        .clock        (clock),
        .reset        (reset),
        .write_i      (buf_write),
        .read_i       (buf_read),
        .flush_i      (EX_MEM_changePC_c),
        .wr_next_pc_i (pc_plus4),
        .wr_ir_i      (imem_resp_data),
        .valid_o      (buf_valid),
        .rd_next_pc_o (buf_next_pc),
        .rd_ir_o      (buf_ir)
    );

    // -------------------------------------------------------------------------
    // Fetch FSM, PC and IF/ID register.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= S_REQ;
            pc_q            <= RESET_PC_W;
            if_id_next_pc_q <= '0;
            if_id_ir_q      <= NOP_INSTR;
        end else if (EX_MEM_changePC_c) begin
            pc_q            <= EX_MEM_targetPC & ALIGN_MASK;
            if_id_next_pc_q <= '0;
            if_id_ir_q      <= NOP_INSTR;
            // S_DROP only if a wrong-path request is still in flight after
            // this edge; its response must be swallowed before refetching.
            case (state_q)
                S_REQ:          state_q <= imem_req_ready  ? S_DROP : S_REQ;
                S_WAIT, S_DROP: state_q <= imem_resp_valid ? S_REQ  : S_DROP;
                default:        state_q <= S_REQ;
            endcase
        end else begin
            // Decode re-latches every unstalled cycle, so anything that is
            // not a fresh instruction must become a bubble.
            if (!id_stall_c) begin
                if (take_direct) begin
                    if_id_next_pc_q <= pc_plus4;
                    if_id_ir_q      <= imem_resp_data;
                end else if (buf_read) begin
                    if_id_next_pc_q <= buf_next_pc;
                    if_id_ir_q      <= buf_ir;
                end else begin
                    if_id_next_pc_q <= '0;
                    if_id_ir_q      <= NOP_INSTR;
                end
            end

            case (state_q)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        pc_q <= pc_plus4;
                        if (id_stall_c) begin
                            state_q <= S_HOLD;
                        end else if (req_fire) begin
                            state_q <= S_WAIT;
                        end else begin
                            state_q <= S_REQ;
                        end
                    end
                end
                S_HOLD: begin
                    if (!id_stall_c) begin
                        state_q <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_resp_valid) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

    assign IF_ID_nextPC = if_id_next_pc_q;
    assign IF_ID_IR     = if_id_ir_q;

`ifndef SYNTHESIS
    // Memory may only answer while a request is outstanding.
    resp_only_when_outstanding : assert property (
        @(posedge clock) disable iff (reset)
        imem_resp_valid |-> (state_q == S_WAIT || state_q == S_DROP)
    );
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Drives fetch_unit against a behavioural instruction memory with variable
// latency and ready, and compares against an instruction-stream model: after
// reset or a redirect to T, the words reaching IF/ID must be exactly
// mem[T], mem[T+4], ... (nextPC = addr+4), with bubbles as {0, NOP} and the
// register frozen while decode stalls.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_stall_c;
    logic        EX_MEM_changePC_c;
    logic [31:0] EX_MEM_targetPC;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] IF_ID_nextPC;
    logic [31:0] IF_ID_IR;
    logic        if_stall_c;

    fetch_unit dut (
        .clock             (clock),
        .reset             (reset),
        .id_stall_c        (id_stall_c),
        .EX_MEM_changePC_c (EX_MEM_changePC_c),
        .EX_MEM_targetPC   (EX_MEM_targetPC),
        .imem_req_valid    (imem_req_valid),
        .imem_req_addr     (imem_req_addr),
        .imem_req_ready    (imem_req_ready),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .IF_ID_nextPC      (IF_ID_nextPC),
        .IF_ID_IR          (IF_ID_IR),
        .if_stall_c        (if_stall_c)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory contents: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h2001_0005 + (a >> 2);
    endfunction

    // Behavioural memory state.
    bit          mem_pending = 1'b0;
    logic [31:0] mem_addr    = '0;
    int          mem_due     = 0;
    int          cyc         = 0;
    int          ready_pct   = 100;
    int          lat_min     = 1;
    int          lat_max     = 1;

    // Stream model state.
    logic [31:0] fetch_ptr   = '0;
    logic [31:0] deliver_ptr = '0;
    logic [31:0] prev_ir     = '0;
    logic [31:0] prev_npc    = '0;
    int          delivered   = 0;

    // Last pre-edge observations, for directed checks.
    logic        last_req_valid;
    logic [31:0] last_req_addr;
    logic        last_sv;

    function automatic bit resp_now();
        return mem_pending && (mem_due == cyc);
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset             = 1'b1;
        id_stall_c        = 1'b0;
        EX_MEM_changePC_c = 1'b0;
        EX_MEM_targetPC   = '0;
        imem_req_ready    = 1'b0;
        imem_resp_valid   = 1'b0;
        imem_resp_data    = '0;
        mem_pending       = 1'b0;
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_ir", IF_ID_IR, 32'h0);
        check("rst_npc", IF_ID_nextPC, 32'h0);
        @(negedge clock);
        reset       = 1'b0;
        fetch_ptr   = 32'h0;
        deliver_ptr = 32'h0;
        prev_ir     = 32'h0;
        prev_npc    = 32'h0;
    endtask

    // One clock cycle: drive inputs, observe, advance memory and stream model.
    task automatic step(input logic stall, input logic redir, input logic [31:0] target);
        bit          resp_v;
        bit          accepted;
        logic        rv;
        logic        sv;
        logic [31:0] ra;
        @(negedge clock);
        resp_v            = resp_now();
        imem_resp_valid   = resp_v;
        imem_resp_data    = resp_v ? mem_word(mem_addr) : $urandom;
        imem_req_ready    = ($urandom_range(0, 99) < ready_pct);
        id_stall_c        = stall;
        EX_MEM_changePC_c = redir;
        EX_MEM_targetPC   = target;
        #1;
        rv = imem_req_valid;
        ra = imem_req_addr;
        sv = if_stall_c;
        last_req_valid = rv;
        last_req_addr  = ra;
        last_sv        = sv;
        if (rv) begin
            check("one_outstanding", {31'b0, mem_pending && !resp_v}, 32'd0);
        end
        accepted = rv && imem_req_ready;
        if (accepted && !redir) begin
            check("req_addr", ra, fetch_ptr);
            fetch_ptr = fetch_ptr + 32'd4;
        end
        @(posedge clock);
        #1;
        if (resp_v) mem_pending = 1'b0;
        if (accepted) begin
            mem_pending = 1'b1;
            mem_addr    = ra;
            mem_due     = cyc + $urandom_range(lat_min, lat_max);
        end
        cyc++;
        if (redir) begin
            check("redir_ir", IF_ID_IR, 32'h0);
            check("redir_npc", IF_ID_nextPC, 32'h0);
            check("redir_if_stall", {31'b0, sv}, 32'd1);
            fetch_ptr   = target & ~32'd3;
            deliver_ptr = target & ~32'd3;
        end else if (stall) begin
            check("hold_ir", IF_ID_IR, prev_ir);
            check("hold_npc", IF_ID_nextPC, prev_npc);
        end else if (sv) begin
            check("bubble_ir", IF_ID_IR, 32'h0);
            check("bubble_npc", IF_ID_nextPC, 32'h0);
        end else begin
            check("stream_ir", IF_ID_IR, mem_word(deliver_ptr));
            check("stream_npc", IF_ID_nextPC, deliver_ptr + 32'd4);
            deliver_ptr = deliver_ptr + 32'd4;
            delivered++;
        end
        prev_ir  = IF_ID_IR;
        prev_npc = IF_ID_nextPC;
    endtask

    // Step unstalled until an instruction is delivered; bounded.
    task automatic run_to_delivery(input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (!last_sv) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        int          d0;
        bit          found;
        logic        stall;
        logic        redir;
        logic [31:0] target;

        // ---- 1: reset, zero-wait memory, back-to-back stream ---------------
        ready_pct = 100; lat_min = 1; lat_max = 1;
        apply_reset();
        step(1'b0, 1'b0, 32'h0);
        check("t1_first_req_valid", {31'b0, last_req_valid}, 32'd1);
        check("t1_first_req_addr", last_req_addr, 32'h0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 32'h0);
            check("t1_no_bubble", {31'b0, last_sv}, 32'd0);
            check("t1_npc", IF_ID_nextPC, 32'd4 * (k + 1));
            check("t1_ir", IF_ID_IR, 32'h2001_0005 + k);
        end

        // ---- 2: decode stall with response arriving -------------------------
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 32'h0);
            if (k > 0) check("t2_hold_no_req", {31'b0, last_req_valid}, 32'd0);
        end
        d0 = delivered;
        step(1'b0, 1'b0, 32'h0);
        check("t2_release_delivers", delivered, d0 + 1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0);

        // ---- 3: redirect in S_WAIT, stale response next cycle ---------------
        lat_min = 2; lat_max = 2;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (mem_pending && !resp_now()) begin
                found = 1'b1;
                break;
            end
            step(1'b0, 1'b0, 32'h0);
        end
        if (!found) check("t3_wait_timeout", 32'd0, 32'd1);
        step(1'b0, 1'b1, 32'h100);
        step(1'b0, 1'b0, 32'h0);
        check("t3_drop_no_req", {31'b0, last_req_valid}, 32'd0);
        check("t3_drop_bubble", IF_ID_IR, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check("t3_refetch_valid", {31'b0, last_req_valid}, 32'd1);
        check("t3_refetch_addr", last_req_addr, 32'h100);

        // ---- 4: redirect coinciding with a response -------------------------
        lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (resp_now()) begin
                found = 1'b1;
                break;
            end
            step(1'b0, 1'b0, 32'h0);
        end
        if (!found) check("t4_resp_timeout", 32'd0, 32'd1);
        step(1'b0, 1'b1, 32'h200);
        step(1'b0, 1'b0, 32'h0);
        check("t4_refetch_valid", {31'b0, last_req_valid}, 32'd1);
        check("t4_refetch_addr", last_req_addr, 32'h200);

        // ---- 5: redirect while stalled with the buffer full -----------------
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bit r;
            r = resp_now();
            step(1'b1, 1'b0, 32'h0);
            if (r) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("t5_fill_timeout", 32'd0, 32'd1);
        step(1'b1, 1'b1, 32'h300);
        run_to_delivery("t5_delivery_timeout");
        check("t5_first_npc", IF_ID_nextPC, 32'h304);
        check("t5_first_ir", IF_ID_IR, mem_word(32'h300));

        // ---- 6: PC wrap and unaligned target --------------------------------
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        run_to_delivery("t6_wrap_timeout");
        check("t6_wrap_npc", IF_ID_nextPC, 32'h0);
        check("t6_wrap_ir", IF_ID_IR, mem_word(32'hFFFF_FFFC));
        check("t6_wrap_next_addr", last_req_addr, 32'h0);
        step(1'b0, 1'b1, 32'h103);
        run_to_delivery("t6_align_timeout");
        check("t6_align_npc", IF_ID_nextPC, 32'h104);
        check("t6_align_ir", IF_ID_IR, mem_word(32'h100));

        // ---- random traffic, including a mid-run reset ----------------------
        ready_pct = 70; lat_min = 1; lat_max = 3;
        d0 = delivered;
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) apply_reset();
            stall = ($urandom_range(0, 3) == 0);
            redir = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) target = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            else                           target = $urandom & 32'h0000_FFFF;
            step(stall, redir, target);
        end
        check("random_progress", {31'b0, (delivered - d0) > 300}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_unit
